rr_arbiter8: RTL and testbench

- Eight-requester round-robin arbiter for one shared resource.
- The winner is held as a 3-bit index and presented both as that index and as its 3-to-8 one-hot decode. The one-hot grant drives the resource select lines.
- Grants are fair rotating-priority with an optional hold limit.
- Sits between the requesting blocks and the shared resource's select/enable inputs.

---
 rtl/rr_arbiter8.sv | 124 ++++++++++++
 tb/tb_rr_arbiter8.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter8.sv
// Eight-requester round-robin arbiter with an optional per-owner hold limit.
// The one-hot grant, winner index and valid flag are all registered outputs.
module rr_arbiter8 #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] req,
  output logic [7:0] grant,
  output logic [2:0] grant_idx,
  output logic       grant_valid
);

  typedef enum logic {IDLE, GRANT} state_e;

  localparam bit               UNLIMITED = (MAX_HOLD == 0);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(UNLIMITED ? 0 : MAX_HOLD - 1);

  state_e           state_q, state_d;
  logic [2:0]       last_q, last_d;
  logic [2:0]       idx_q, idx_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [7:0]       grant_q, grant_d;

  logic [7:0] owner_mask;
  logic [3:0] win, win_x;
  logic       take;
  logic [2:0] take_idx;

  // Returns {found, index}; scans ptr+1 .. ptr+8 so the pointer slot is tried last.
  function automatic logic [3:0] rr_search(input logic [7:0] mask, input logic [2:0] ptr);
    logic [3:0] res;
    logic [2:0] pos;
    res = '0;
    for (int k = 8; k >= 1; k--) begin
      pos = ptr + 3'(k);
      if (mask[pos]) res = {1'b1, pos};
    end
    return res;
  endfunction

  assign owner_mask = 8'b1 << idx_q;
  assign win        = rr_search(req, last_q);
  assign win_x      = rr_search(req & ~owner_mask, last_q);

  always_comb begin
    // NOTE: every variable gets a default here so no path leaves it unassigned (no latches).
    state_d    = state_q;
    last_d     = last_q;
    idx_d      = idx_q;
    valid_d    = valid_q;
    hold_cnt_d = hold_cnt_q;
    take       = 1'b0;
    take_idx   = win[2:0];

    unique case (state_q)
      IDLE: begin
        if (en && win[3]) take = 1'b1;
      end
      GRANT: begin
        if (!req[idx_q]) begin
          if (en && win[3]) begin
            take = 1'b1;
          end else begin
            state_d    = IDLE;
            valid_d    = 1'b0;
            hold_cnt_d = '0;
          end
        end else if (!UNLIMITED && hold_cnt_q == HOLD_LAST) begin
          if (!en) begin
            state_d    = IDLE;
            valid_d    = 1'b0;
            hold_cnt_d = '0;
          end else if (win_x[3]) begin
            take     = 1'b1;
            take_idx = win_x[2:0];
          end else begin
            hold_cnt_d = '0;  // sole requester keeps the grant, window restarts
          end
        end else if (hold_cnt_q != '1) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (take) begin
      state_d    = GRANT;
      idx_d      = take_idx;
      last_d     = take_idx;
      valid_d    = 1'b1;
      hold_cnt_d = '0;
    end

    grant_d = valid_d ? (8'b1 << idx_d) : 8'h00;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      last_q     <= 3'd7;
      idx_q      <= 3'd0;
      valid_q    <= 1'b0;
      hold_cnt_q <= '0;
      grant_q    <= 8'h00;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      idx_q      <= idx_d;
      valid_q    <= valid_d;
      hold_cnt_q <= hold_cnt_d;
      grant_q    <= grant_d;
    end
  end

  assign grant       = grant_q;
  assign grant_idx   = idx_q;
  assign grant_valid = valid_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8: two instances (hold limit 4 and unlimited) on shared
// stimulus, a cycle model per instance, plus directed literal expectations.
module tb_rr_arbiter8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [7:0] req = 8'h00;

  logic [7:0] ga, gb;
  logic [2:0] gia, gib;
  logic       gva, gvb;

  int checks = 0;
  int errors = 0;

  rr_arbiter8 #(.MAX_HOLD(4), .CNT_W(8)) u_a (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .grant(ga), .grant_idx(gia), .grant_valid(gva)
  );

  rr_arbiter8 #(.MAX_HOLD(0), .CNT_W(8)) u_b (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .grant(gb), .grant_idx(gib), .grant_valid(gvb)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state per instance: [0] hold limit 4, [1] unlimited.
  int m_limit[2] = '{4, 0};
  int m_valid[2];
  int m_idx[2];
  int m_ptr[2];
  int m_held[2];

  function automatic int find_next(input logic [7:0] r, input int ptr);
    for (int k = 1; k <= 8; k++) begin
      if (r[(ptr + k) % 8]) return (ptr + k) % 8;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_valid[m] = 0; m_idx[m] = 0; m_ptr[m] = 7; m_held[m] = 0;
    end
  endtask

  task automatic model_award(input int m, input int w);
    m_valid[m] = 1; m_idx[m] = w; m_ptr[m] = w; m_held[m] = 0;
  endtask

  task automatic model_step(input logic e, input logic [7:0] r);
    logic [7:0] others;
    int o;
    for (int m = 0; m < 2; m++) begin
      o = m_idx[m];
      if (m_valid[m] == 0) begin
        if (e && r != 0) model_award(m, find_next(r, m_ptr[m]));
      end else if (!r[o]) begin
        if (e && r != 0) model_award(m, find_next(r, m_ptr[m]));
        else begin m_valid[m] = 0; m_held[m] = 0; end
      end else if (m_limit[m] != 0 && m_held[m] + 1 >= m_limit[m]) begin
        others = r;
        others[o] = 1'b0;
        if (!e) begin m_valid[m] = 0; m_held[m] = 0; end
        else if (others != 0) model_award(m, find_next(others, m_ptr[m]));
        else m_held[m] = 0;
      end else begin
        m_held[m]++;
      end
    end
  endtask

  function automatic logic [7:0] model_grant(input int m);
    return m_valid[m] != 0 ? 8'(1 << m_idx[m]) : 8'h00;
  endfunction

  always @(posedge rst) model_reset();

  // Per-cycle compare of both instances against the model.
  always @(posedge clk) begin
    if (rst) model_reset();
    else model_step(en, req);
    #1;
    check("a.grant",       32'(ga),  32'(model_grant(0)));
    check("a.grant_idx",   32'(gia), 32'(m_idx[0]));
    check("a.grant_valid", 32'(gva), 32'(m_valid[0]));
    check("b.grant",       32'(gb),  32'(model_grant(1)));
    check("b.grant_idx",   32'(gib), 32'(m_idx[1]));
    check("b.grant_valid", 32'(gvb), 32'(m_valid[1]));
    check("a.onehot0", 32'($onehot0(ga)), 32'd1);
    check("b.onehot0", 32'($onehot0(gb)), 32'd1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    tick(2);
    rst = 1'b0;

    // Idle with no requests.
    en = 1'b1; req = 8'h00;
    for (int n = 0; n < 5; n++) begin
      tick(1);
      check("t1.grant", 32'(ga), 32'h00);
      check("t1.valid", 32'(gva), 32'd0);
      check("t1.idx",   32'(gia), 32'd0);
    end

    // Asynchronous reset mid-cycle while a grant is live.
    req = 8'h04;
    tick(1);
    check("t1.pre_rst_grant", 32'(ga), 32'h04);
    #2 rst = 1'b1;
    #1;
    check("t1.async_grant", 32'(ga), 32'h00);
    check("t1.async_valid", 32'(gva), 32'd0);
    check("t1.async_idx",   32'(gia), 32'd0);
    req = 8'h00;
    tick(1);
    rst = 1'b0;

    // Single request, then release.
    req = 8'h01;
    tick(1);
    check("t2.grant", 32'(ga), 32'h01);
    check("t2.idx",   32'(gia), 32'd0);
    check("t2.valid", 32'(gva), 32'd1);
    req = 8'h00;
    tick(1);
    check("t2.rel_grant", 32'(ga), 32'h00);
    check("t2.rel_valid", 32'(gva), 32'd0);
    check("t2.rel_idx",   32'(gia), 32'd0);

    // All requesting with hold limit 4: each owner holds 4 cycles, no gaps.
    do_reset();
    req = 8'hFF;
    for (int n = 1; n <= 33; n++) begin
      tick(1);
      check("t3.idx",   32'(gia), 32'(((n - 1) / 4) % 8));
      check("t3.valid", 32'(gva), 32'd1);
    end
    req = 8'h00;
    tick(2);

    // Fairness and pointer wrap on the unlimited instance.
    do_reset();
    req = 8'h81;
    tick(1);
    check("t4.first", 32'(gb), 32'h01);
    req = 8'h80;
    tick(1);
    check("t4.second", 32'(gb), 32'h80);
    req = 8'h03;
    tick(1);
    check("t4.wrap", 32'(gb), 32'h01);
    req = 8'h00;
    tick(2);

    // Lone requester across several hold windows.
    do_reset();
    req = 8'h20;
    for (int n = 1; n <= 12; n++) begin
      tick(1);
      check("t5.grant", 32'(ga), 32'h20);
      check("t5.valid", 32'(gva), 32'd1);
      check("t5.hold_cnt", 32'(u_a.hold_cnt_q), 32'((n - 1) % 4));
    end
    req = 8'h00;
    tick(2);

    // Enable gating.
    do_reset();
    en = 1'b0; req = 8'h10;
    tick(2);
    check("t6.gated_grant", 32'(ga), 32'h00);
    check("t6.gated_valid", 32'(gva), 32'd0);
    en = 1'b1;
    tick(1);
    check("t6.en_grant", 32'(ga), 32'h10);
    en = 1'b0; req = 8'h18;
    for (int n = 0; n < 2; n++) begin
      tick(1);
      check("t6.persist", 32'(ga), 32'h10);
    end
    req = 8'h08;
    tick(1);
    check("t6.idle_grant", 32'(ga), 32'h00);
    check("t6.idle_valid", 32'(gva), 32'd0);
    check("t6.idle_idx",   32'(gia), 32'd4);
    check("t6.b_idle_grant", 32'(gb), 32'h00);

    en = 1'b1; req = 8'h10;
    tick(1);
    check("t6.regrant", 32'(ga), 32'h10);
    #2 rst = 1'b1;
    #1;
    check("t6.rst_grant", 32'(ga), 32'h00);
    check("t6.rst_valid", 32'(gva), 32'd0);
    req = 8'h00;
    tick(1);
    rst = 1'b0;
    req = 8'h09;
    tick(1);
    check("t6.after_rst", 32'(ga), 32'h01);
    check("t6.after_rst_b", 32'(gb), 32'h01);
    req = 8'h00;
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
